// File: rtl/mips_pkg.sv
// Shared definitions for the mips_core fetch path: word width, the NOP word
// returned on suppressed slots, the fetch-stage record and address checking.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] pc;
    logic              error;
  } fetch_stage_t;

  // A word address is bad when it is not word aligned or falls beyond the
  // array (addr_bits = log2 of the array depth in words).
  function automatic logic addr_is_bad(input logic [WORD_W-1:0] addr,
                                       input int                addr_bits);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_bits + 2)) != '0);
  endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response and program-load bundle between the core (master)
// and the instruction-memory responder (slave).
interface imem_fetch_responder_if;
  import mips_pkg::*;

  logic              req_valid;
  logic [WORD_W-1:0] req_addr;
  logic              req_ready;
  logic              flush;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_pc;
  logic [WORD_W-1:0] rsp_instruction;
  logic              rsp_error;
  logic              load_en;
  logic [WORD_W-1:0] load_addr;
  logic [WORD_W-1:0] load_data;
  logic [2:0]        inflight;

  modport master (
    output req_valid, req_addr, flush, load_en, load_addr, load_data,
    input  req_ready, rsp_valid, rsp_pc, rsp_instruction, rsp_error, inflight
  );

  modport slave (
    input  req_valid, req_addr, flush, load_en, load_addr, load_data,
    output req_ready, rsp_valid, rsp_pc, rsp_instruction, rsp_error, inflight
  );

endinterface

// File: rtl/imem_array.sv
// Single-port instruction word array: synchronous write, registered read.
// The contents are deliberately not reset so a program survives a core reset.
module imem_array
  import mips_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Program words are written on the edge where the write is enabled.
  always_ff @(posedge clock) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port register; it only updates on a read so it holds between fetches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch-side instruction memory responder. Requests flow through a LATENCY
// deep pipeline of {valid, pc, error} records; the word is read from the
// array in stage 1 and carried down the remaining stages. Flush clears all
// in-flight records but still accepts a request in the same cycle.
module imem_fetch_responder
  import mips_pkg::*;
#(
  parameter int                DEPTH_WORDS = 256,
  parameter int                LATENCY     = 1,
  parameter logic [WORD_W-1:0] NOP_INSTR   = mips_pkg::NOP_INSTR
) (
  input  logic                   clock,
  input  logic                   reset,
  imem_fetch_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic              accept;
  logic              req_bad;
  logic              load_bad;
  logic              load_ok;
  logic              mem_en;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] rd_data;
  logic [WORD_W-1:0] s1_instr;
  logic [WORD_W-1:0] last_instr;
  logic              show;
  logic [WORD_W-1:0] hold_pc;
  logic [WORD_W-1:0] hold_instr;
  logic              hold_error;
  logic [2:0]        count;

  fetch_stage_t stage [1:LATENCY];

  assign req_bad       = addr_is_bad(bus.req_addr, AW);
  assign load_bad      = addr_is_bad(bus.load_addr, AW);
  assign bus.req_ready = !bus.load_en && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign load_ok       = bus.load_en && !load_bad && !reset;
  assign mem_en        = load_ok || (accept && !req_bad);
  assign mem_addr      = bus.load_en ? bus.load_addr[AW+1:2] : bus.req_addr[AW+1:2];

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .en    (mem_en),
    .we    (load_ok),
    .addr  (mem_addr),
    .wdata (bus.load_data),
    .rdata (rd_data)
  );

  assign s1_instr = stage[1].error ? NOP_INSTR : rd_data;

  // Advance request records one stage per cycle; flush drops everything older
  // than the request accepted on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= LATENCY; k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[1].valid <= accept;
      if (accept) begin
        stage[1].pc    <= bus.req_addr;
        stage[1].error <= req_bad;
      end
      for (int k = 2; k <= LATENCY; k++) begin
        stage[k] <= stage[k-1];
        if (bus.flush) begin
          stage[k].valid <= 1'b0;
        end
      end
    end
  end

  generate
    if (LATENCY > 1) begin : g_data_pipe
      logic [WORD_W-1:0] data_q [2:LATENCY];

      // Carry the fetched word alongside its record through the later stages.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 2; k <= LATENCY; k++) begin
            data_q[k] <= NOP_INSTR;
          end
        end else begin
          data_q[2] <= s1_instr;
          for (int k = 3; k <= LATENCY; k++) begin
            data_q[k] <= data_q[k-1];
          end
        end
      end

      assign last_instr = data_q[LATENCY];
    end else begin : g_no_data_pipe
      assign last_instr = s1_instr;
    end
  endgenerate

  assign show = stage[LATENCY].valid && !bus.flush;

  // Remember the last delivered response so outputs hold it while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
      hold_error <= 1'b0;
    end else if (show) begin
      hold_pc    <= stage[LATENCY].pc;
      hold_instr <= last_instr;
      hold_error <= stage[LATENCY].error;
    end
  end

  // Present the final stage when it is due, otherwise the held response.
  always_comb begin
    bus.rsp_valid       = show;
    bus.rsp_pc          = hold_pc;
    bus.rsp_instruction = hold_instr;
    bus.rsp_error       = hold_error;
    if (show) begin
      bus.rsp_pc          = stage[LATENCY].pc;
      bus.rsp_instruction = last_instr;
      bus.rsp_error       = stage[LATENCY].error;
    end
  end

  // In-flight count is the number of occupied pipeline stages.
  always_comb begin
    count = '0;
    for (int k = 1; k <= LATENCY; k++) begin
      count = count + {2'b00, stage[k].valid};
    end
  end

  assign bus.inflight = count;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: three instances (LATENCY 1, 2, 3) share one
// stimulus stream. A request-level reference model predicts, for every cycle,
// which response is due, the held outputs and the in-flight count.
module tb_imem_fetch_responder;
  import mips_pkg::*;

  localparam int NDUT = 3;

  logic        clock     = 1'b0;
  logic        reset     = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr  = '0;
  logic        flush     = 1'b0;
  logic        load_en   = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic        obs_ready [NDUT];
  logic        obs_valid [NDUT];
  logic [31:0] obs_pc    [NDUT];
  logic [31:0] obs_instr [NDUT];
  logic        obs_err   [NDUT];
  logic [2:0]  obs_infl  [NDUT];

  always #5 clock = ~clock;

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      imem_fetch_responder_if bus ();

      assign bus.req_valid = req_valid;
      assign bus.req_addr  = req_addr;
      assign bus.flush     = flush;
      assign bus.load_en   = load_en;
      assign bus.load_addr = load_addr;
      assign bus.load_data = load_data;

      assign obs_ready[g] = bus.req_ready;
      assign obs_valid[g] = bus.rsp_valid;
      assign obs_pc[g]    = bus.rsp_pc;
      assign obs_instr[g] = bus.rsp_instruction;
      assign obs_err[g]   = bus.rsp_error;
      assign obs_infl[g]  = bus.inflight;

      imem_fetch_responder #(
        .DEPTH_WORDS (256),
        .LATENCY     (g + 1),
        .NOP_INSTR   (32'h0000_0000)
      ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
      );
    end
  endgenerate

  typedef struct {
    int          n;
    logic [31:0] pc;
    logic        err;
    logic [31:0] instr;
  } req_t;

  req_t        reqs[$];
  int          flushes[$];
  logic [31:0] mem_model [256];
  int          edge_n = 0;
  logic [31:0] last_pc    [NDUT];
  logic [31:0] last_instr [NDUT];
  logic        last_err   [NDUT];
  int          checks = 0;
  int          errors = 0;

  // One clock cycle: drive inputs mid-cycle, compare every instance against
  // the model, then let the edge happen and record what it accepted.
  task automatic tick(input logic rv, input logic [31:0] ra, input logic fl,
                      input logic le, input logic [31:0] la,
                      input logic [31:0] ld, input logic rs);
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_err;
    int          exp_infl;
    int          lat;
    bit          killed;
    req_t        r;
    req_valid = rv;
    req_addr  = ra;
    flush     = fl;
    load_en   = le;
    load_addr = la;
    load_data = ld;
    reset     = rs;
    if (rs) begin
      reqs.delete();
      flushes.delete();
      for (int i = 0; i < NDUT; i++) begin
        last_pc[i]    = '0;
        last_instr[i] = 32'h0000_0000;
        last_err[i]   = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < NDUT; i++) begin
      lat       = i + 1;
      exp_valid = 1'b0;
      exp_infl  = 0;
      exp_pc    = last_pc[i];
      exp_instr = last_instr[i];
      exp_err   = last_err[i];
      foreach (reqs[j]) begin
        killed = 1'b0;
        foreach (flushes[f]) begin
          if (reqs[j].n < flushes[f] && flushes[f] <= reqs[j].n + lat) killed = 1'b1;
        end
        if (!killed && edge_n < reqs[j].n + lat) begin
          exp_infl++;
          if (reqs[j].n + lat - 1 == edge_n && !fl) begin
            exp_valid = 1'b1;
            exp_pc    = reqs[j].pc;
            exp_instr = reqs[j].instr;
            exp_err   = reqs[j].err;
          end
        end
      end
      checks++;
      if (obs_ready[i] !== (!le && !rs)) begin
        errors++;
        $display("[TB] FAIL req_ready lat=%0d cycle=%0d got=%b exp=%b", lat, edge_n, obs_ready[i], !le && !rs);
      end
      checks++;
      if (obs_valid[i] !== exp_valid) begin
        errors++;
        $display("[TB] FAIL rsp_valid lat=%0d cycle=%0d got=%b exp=%b", lat, edge_n, obs_valid[i], exp_valid);
      end
      checks++;
      if (obs_pc[i] !== exp_pc) begin
        errors++;
        $display("[TB] FAIL rsp_pc lat=%0d cycle=%0d got=%h exp=%h", lat, edge_n, obs_pc[i], exp_pc);
      end
      checks++;
      if (obs_instr[i] !== exp_instr) begin
        errors++;
        $display("[TB] FAIL rsp_instruction lat=%0d cycle=%0d got=%h exp=%h", lat, edge_n, obs_instr[i], exp_instr);
      end
      checks++;
      if (obs_err[i] !== exp_err) begin
        errors++;
        $display("[TB] FAIL rsp_error lat=%0d cycle=%0d got=%b exp=%b", lat, edge_n, obs_err[i], exp_err);
      end
      checks++;
      if (obs_infl[i] !== 3'(exp_infl)) begin
        errors++;
        $display("[TB] FAIL inflight lat=%0d cycle=%0d got=%0d exp=%0d", lat, edge_n, obs_infl[i], exp_infl);
      end
      if (exp_valid) begin
        last_pc[i]    = exp_pc;
        last_instr[i] = exp_instr;
        last_err[i]   = exp_err;
      end
    end
    @(posedge clock);
    edge_n++;
    if (!rs) begin
      if (fl) flushes.push_back(edge_n);
      if (rv && !le) begin
        r.n     = edge_n;
        r.pc    = ra;
        r.err   = (ra % 4 != 0) || (ra >= 32'd1024);
        r.instr = r.err ? 32'h0000_0000 : mem_model[ra[9:2]];
        reqs.push_back(r);
      end
      if (le && (la % 4 == 0) && (la < 32'd1024)) mem_model[la[9:2]] = ld;
    end
    while (reqs.size() > 0 && reqs[0].n + 8 < edge_n) void'(reqs.pop_front());
    while (flushes.size() > 0 && flushes[0] + 8 < edge_n) void'(flushes.pop_front());
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] a);
    tick(1'b1, a, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    tick(1'b0, '0, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    tick(1'b1, 32'h4, 1'b1, 1'b0, '0, '0, 1'b1);
    idle(1);
  endtask

  task automatic test_preload();
    for (int i = 0; i < 256; i++) load(32'(i) * 4, $urandom);
  endtask

  task automatic test_program_load();
    load(32'h0, 32'h2008_0005);
    load(32'h4, 32'h2009_0003);
    load(32'h8, 32'h0109_5020);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    idle(4);
  endtask

  task automatic test_latency_stream();
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);
    fetch(32'h0);
    idle(4);
  endtask

  task automatic test_errors();
    fetch(32'h6);
    fetch(32'h400);
    fetch(32'hFFFF_FFFC);
    fetch(32'h3FC);
    idle(4);
  endtask

  task automatic test_flush();
    fetch(32'h0);
    fetch(32'h4);
    tick(1'b1, 32'h8, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(4);
    tick(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(1);
  endtask

  task automatic test_load_priority();
    tick(1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    fetch(32'h10);
    load(32'h12, 32'h1234_5678);
    load(32'h800, 32'h8765_4321);
    fetch(32'h10);
    idle(4);
  endtask

  task automatic test_async_reset();
    fetch(32'h0);
    fetch(32'h4);
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    idle(4);
    fetch(32'h0);
    idle(4);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] la;
    int          sel;
    for (int c = 0; c < 600; c++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = (32'($urandom_range(0, 255)) * 4) + 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'h400 + 32'($urandom_range(0, 4095)) * 4;
      else               a = 32'($urandom_range(0, 255)) * 4;
      sel = int'($urandom_range(0, 9));
      la  = (sel == 0) ? $urandom : 32'($urandom_range(0, 255)) * 4;
      tick($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, la, $urandom, $urandom_range(0, 99) == 0);
    end
    idle(5);
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      last_pc[i]    = '0;
      last_instr[i] = '0;
      last_err[i]   = 1'b0;
    end
    test_reset();
    test_preload();
    test_program_load();
    test_latency_stream();
    test_errors();
    test_flush();
    test_load_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
Instruction-memory responder on the fetch side of mips_core. It accepts PC fetch requests from the core and returns the addressed instruction word after a fixed pipeline latency. A load port lets the bench or boot logic write program words. A flush input discards in-flight fetches on a branch redirect.

Parameters:
DEPTH_WORDS, 256, number of 32-bit instruction words; must be a power of two.
LATENCY, 1, request-to-response delay in cycles; legal range 1..4.
NOP_INSTR, 32'h00000000, word returned on error or flush-suppressed slots.

Ports:
clock  input  1  single system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  core presents a fetch request.
req_addr  input  32  byte address (PC) to fetch.
req_ready  output  1  responder can accept a request this cycle.
flush  input  1  discard all in-flight fetches (branch/jump redirect).
rsp_valid  output  1  response word valid this cycle.
rsp_pc  output  32  address of the request being answered.
rsp_instruction  output  32  fetched instruction word.
rsp_error  output  1  the request was misaligned or out of range.
load_en  input  1  write a program word this cycle.
load_addr  input  32  byte address of the program word.
load_data  input  32  program word.
inflight  output  3  number of accepted requests not yet answered.

Behaviour:
- Reset (async assert, deassert synchronised to clock by the surrounding design):
  - rsp_valid=0, rsp_pc=0, rsp_instruction=NOP_INSTR, rsp_error=0.
  - inflight=0; all pipeline valid bits cleared.
  - Memory array is NOT cleared; contents survive reset.
- req_ready = !load_en && !reset. The load port has absolute priority.
- A request is accepted when req_valid && req_ready at a clock edge. Acceptance is unconditional otherwise: one per cycle, no response backpressure.
- Address decode:
  - index = req_addr[log2(DEPTH_WORDS)+1:2].
  - Error if req_addr[1:0] != 0, or if req_addr >= 4*DEPTH_WORDS.
  - On error: rsp_instruction=NOP_INSTR, rsp_error=1, no memory access.
- Latency: a request accepted at edge N yields rsp_valid=1 with matching rsp_pc/rsp_instruction/rsp_error during the cycle after edge N+LATENCY-1. With LATENCY=1, the response is visible for the cycle following the accepting edge.
- Pipeline: LATENCY stages, each holding {valid, pc, error}. The memory read occurs in stage 1; data is carried through the later stages.
- Ordering: responses return strictly in request order.
- rsp_valid is a one-cycle pulse per request. When no response is due, rsp_valid=0 and the other response outputs hold their last values.
- inflight: incremented on accept, decremented on response. Both in one cycle leaves it unchanged. Maximum value is LATENCY.
- flush:
  - At the clock edge where flush=1, all stage valid bits clear and inflight becomes 0.
  - A request presented in the same cycle as flush IS accepted; it belongs to the new stream.
  - rsp_valid is forced 0 in the cycle flush is high.
- Load:
  - Write occurs at the edge with load_en=1.
  - A misaligned or out-of-range load is silently ignored.
  - A read accepted on the next edge returns the new data (no stale bypass needed, since reads and writes are never simultaneous).
- Reset asserted mid-stream aborts all in-flight responses; no response is produced for them after reset releases.
- Address wrap is not supported: addresses at or above 4*DEPTH_WORDS are errors, not aliases.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR constant (shared with the decoder).
  - WORD_W=32.
  - Typedef of the fetch-stage record {valid, pc, error}.
- One natural sub-module: imem_array, a single-port synchronous-write, registered-read word array with its own DEPTH_WORDS parameter.
- The latency pipeline and flush logic stay in the top module.

Test Plan:
- Load 0x20080005 @0x0, 0x20090003 @0x4, 0x01095020 @0x8; LATENCY=1; request 0x0, 0x4, 0x8 back-to-back -> three consecutive rsp_valid pulses with those words and rsp_pc 0,4,8; rsp_error=0.
- LATENCY=3; request 0x4 at edge 1 -> rsp_valid first high after edge 3, instruction 0x20090003; inflight reads 1,2,3 while streaming one request per cycle.
- Request 0x6 and 0x400 (DEPTH_WORDS=256) -> rsp_error=1, rsp_instruction=0x00000000 for both, in order.
- LATENCY=2; requests 0x0, 0x4 then flush together with request 0x8 -> no responses for 0x0 and 0x4; a single response for 0x8; inflight goes 2 -> 1.
- load_en=1 with req_valid=1 at 0x10 -> req_ready=0 and request not accepted. Next cycle, retry read of 0x10 -> returns the newly loaded word 0xDEADBEEF.
- Assert reset asynchronously mid-clock with inflight=2 -> outputs reach reset values immediately. After release: no stale rsp_valid; a reread of 0x0 returns 0x20080005 (memory preserved).
